ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch unit for the LC-3b pipeline. It holds the PC and issues reads to instruction memory over the read/resp handshake. It buffers one fetched instruction and hands it to decode through a valid/ready handshake, presenting the opcode and bits 11/5/4 that drive the control ROM. Redirects (branches, JMP, TRAP) from later stages flush the buffered instruction and any in-flight read.

## Interface
- RESET_PC, default 16'h0000: PC loaded on reset.

- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_read  out  1  read request, held until imem_resp.
- imem_address  out  16  read address, stable while imem_read=1.
- imem_resp  in  1  read complete this cycle; imem_rdata valid.
- imem_rdata  in  16  instruction word.
- redirect  in  1  flush and restart at redirect_pc.
- redirect_pc  in  16  new fetch address; bit 0 ignored (treated as 0).
- id_ready  in  1  decode accepts the instruction this cycle.
- if_valid  out  1  if_* outputs hold a valid instruction.
- if_ir  out  16  buffered instruction.
- if_pc  out  16  address of if_ir.
- if_pc_plus2  out  16  if_pc + 2, modulo 2^16.
- opcode  out  4  if_ir[15:12] (lc3b_opcode).
- bit11 / bit5 / bit4  out  1 each  if_ir[11], if_ir[5], if_ir[4].

## Operation
- **Registers:**
  - pc: next fetch address.
  - addr_q: address of the outstanding read.
  - ir, fetch_pc: the buffered instruction and its address.
  - state: one of IDLE, FETCH, HOLD, DISCARD.
- **Reset values:** state=IDLE, pc=RESET_PC, addr_q=RESET_PC, ir=0, fetch_pc=0. Outputs during reset: imem_read=0, if_valid=0, if_ir=0, opcode=0.
- **Output decode:**
  - imem_read=1 in FETCH and DISCARD only.
  - imem_address=addr_q.
  - if_valid=1 in HOLD only.
- **IDLE:** next cycle → FETCH; addr_q←pc.
- **FETCH:**
  - redirect & imem_resp: drop data; pc←redirect_pc; addr_q←redirect_pc; stay FETCH.
  - redirect & !imem_resp: pc←redirect_pc; addr_q unchanged; → DISCARD.
  - imem_resp: ir←imem_rdata; fetch_pc←pc; pc←pc+2; → HOLD.
  - Otherwise hold.
- **HOLD:**
  - redirect has priority over id_ready: pc←redirect_pc; addr_q←redirect_pc; → FETCH. The instruction is not accepted even if id_ready=1.
  - id_ready: addr_q←pc; → FETCH.
  - Otherwise hold; ir and fetch_pc stay stable.
- **DISCARD:**
  - redirect: pc←redirect_pc; stay DISCARD.
  - imem_resp (with or without redirect): drop data; addr_q←pc (the updated pc if redirect is also asserted); → FETCH.
- **Arithmetic:** pc+2 wraps, so 16'hFFFE → 16'h0000. if_pc_plus2 is computed the same way.
- **Redirect targets:** bit 0 of redirect_pc is written as 0.
- **Reset mid-operation:** async reset returns the block to IDLE immediately. A response for a read that was pending is not captured.

## Timing
- **Minimum fetch latency:** enter FETCH at cycle t, imem_resp at t → if_valid=1 at t+1.
- **Peak throughput:** one instruction per 2 cycles (HOLD→FETCH→HOLD) with zero-wait memory.
- **Decode side:**
  - if_* outputs are registered; the opcode/bit outputs are combinational slices of ir.
  - A transfer occurs on a cycle with if_valid & id_ready & !redirect.
- **Memory side:** imem_address and imem_read never change while a request is outstanding, except on the cycle after imem_resp.

## Structure
- **lc3b_types package:**
  - Reuses lc3b_word and lc3b_opcode.
  - Adds enum lc3b_fetch_state {IDLE, FETCH, HOLD, DISCARD}.
  - Adds constant LC3B_PC_INC = 16'd2.
- **Sub-module ifetch_control:** the state register plus next-state and load-enable decode. It produces pc_load, pc_sel (inc/redirect), addr_load, ir_load, imem_read and if_valid.
- **Datapath registers:** pc, addr_q, ir and fetch_pc use the existing generic load-enabled register.

## Test plan
- **Reset/first fetch:** reset, then release. Cycle 1 is IDLE with imem_read=0. Next cycle imem_read=1 with address 0x0000. Return resp with rdata 0x1042 → if_valid=1, opcode=4'h1, bit5=0, if_pc=0x0000, if_pc_plus2=0x0002.
- **Stall:** hold id_ready=0 for 5 cycles in HOLD → if_ir stays 0x1042 and imem_read stays 0. Raise id_ready → next request is to address 0x0002.
- **Redirect in FETCH, no resp:** redirect to 0x3001 → address stays 0x0002 until resp; that data is dropped. Next request is to 0x3000, and if_valid never rises for the 0x0002 data.
- **Redirect in HOLD together with id_ready:** no transfer occurs. Next address equals redirect_pc and if_valid=0.
- **Wrap:** RESET_PC=16'hFFFE, fetch one instruction → if_pc_plus2=0x0000 and next address 0x0000.
- **Async reset in DISCARD:** assert reset between clock edges → outputs are at reset values immediately. A late imem_resp produces no if_valid.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions for the fetch slice.
//   lc3b_word        : 16-bit machine word
//   lc3b_opcode      : 4-bit opcode field (ir[15:12])
//   lc3b_fetch_state : fetch sequencer states
//   lc3b_pc_sel      : next-pc source select
//   LC3B_PC_INC      : sequential pc increment
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DISCARD
    } lc3b_fetch_state;

    typedef enum logic {
        PC_SEL_INC,
        PC_SEL_REDIRECT
    } lc3b_pc_sel;

    localparam lc3b_word LC3B_PC_INC = 16'd2;

endpackage

// File: rtl/ifetch_unit_control.sv
// Fetch sequencer: state register plus next-state and load-enable decode.
//   clk, reset       : clock, async active-high reset (-> IDLE)
//   redirect         : flush request from later stages
//   imem_resp        : instruction memory read complete
//   id_ready         : decode accepts the buffered instruction
//   pc_load, pc_sel  : pc write enable and source (increment / redirect)
//   addr_load        : capture next pc into the request address register
//   ir_load          : capture imem_rdata and its address
//   imem_read        : read request level
//   if_valid         : buffered instruction valid
module ifetch_control
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       redirect,
    input  logic       imem_resp,
    input  logic       id_ready,
    output logic       pc_load,
    output lc3b_pc_sel pc_sel,
    output logic       addr_load,
    output logic       ir_load,
    output logic       imem_read,
    output logic       if_valid
);

    lc3b_fetch_state state_q;
    lc3b_fetch_state state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_load   = 1'b0;
        pc_sel    = PC_SEL_INC;
        addr_load = 1'b0;
        ir_load   = 1'b0;
        imem_read = 1'b0;
        if_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                addr_load = 1'b1;
                state_d   = FETCH;
            end
            FETCH: begin
                imem_read = 1'b1;
                if (redirect) begin
                    pc_load = 1'b1;
                    pc_sel  = PC_SEL_REDIRECT;
                    if (imem_resp) begin
                        // Response arrived with the flush: drop it and
                        // immediately re-issue at the redirect target.
                        addr_load = 1'b1;
                    end else begin
                        // Address must stay stable until the stale read ends.
                        state_d = DISCARD;
                    end
                end else if (imem_resp) begin
                    pc_load = 1'b1;
                    ir_load = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if_valid = 1'b1;
                if (redirect) begin
                    pc_load   = 1'b1;
                    pc_sel    = PC_SEL_REDIRECT;
                    addr_load = 1'b1;
                    state_d   = FETCH;
                end else if (id_ready) begin
                    addr_load = 1'b1;
                    state_d   = FETCH;
                end
            end
            DISCARD: begin
                imem_read = 1'b1;
                if (redirect) begin
                    pc_load = 1'b1;
                    pc_sel  = PC_SEL_REDIRECT;
                end
                if (imem_resp) begin
                    addr_load = 1'b1;
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/lc3b_register.sv
// Generic load-enabled register with asynchronous active-high reset.
//   clk, reset : clock, async reset (loads RESET_VAL)
//   load       : capture data_in on the rising edge
//   data_in    : next value
//   data_out   : registered value
module lc3b_register #(
    parameter int unsigned WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/ifetch_unit.sv
// LC-3b instruction fetch unit.
//   clk, reset                 : clock, async active-high reset
//   imem_read/address          : read request to instruction memory
//   imem_resp/rdata            : read completion and instruction word
//   redirect, redirect_pc      : flush and restart (bit 0 forced to 0)
//   id_ready                   : decode accepts if_* this cycle
//   if_valid/ir/pc/pc_plus2    : buffered instruction to decode
//   opcode, bit11, bit5, bit4  : control-ROM fields sliced from if_ir
module ifetch_unit
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic       clk,
    input  logic       reset,
    output logic       imem_read,
    output lc3b_word   imem_address,
    input  logic       imem_resp,
    input  lc3b_word   imem_rdata,
    input  logic       redirect,
    input  lc3b_word   redirect_pc,
    input  logic       id_ready,
    output logic       if_valid,
    output lc3b_word   if_ir,
    output lc3b_word   if_pc,
    output lc3b_word   if_pc_plus2,
    output lc3b_opcode opcode,
    output logic       bit11,
    output logic       bit5,
    output logic       bit4
);

    logic       pc_load;
    lc3b_pc_sel pc_sel;
    logic       addr_load;
    logic       ir_load;

    lc3b_word pc_q;
    lc3b_word pc_d;
    lc3b_word pc_next;

    ifetch_control u_control (
        .clk       (clk),
        .reset     (reset),
        .redirect  (redirect),
        .imem_resp (imem_resp),
        .id_ready  (id_ready),
        .pc_load   (pc_load),
        .pc_sel    (pc_sel),
        .addr_load (addr_load),
        .ir_load   (ir_load),
        .imem_read (imem_read),
        .if_valid  (if_valid)
    );

    always_comb begin
        pc_d = pc_q + LC3B_PC_INC;
        if (pc_sel == PC_SEL_REDIRECT) begin
            pc_d = {redirect_pc[15:1], 1'b0};
        end
    end

    // Every addr_q load takes the pc value as it will be after this edge
    // (redirect target if one is being taken), so the address register is
    // fed from the pc write-through rather than a separate mux.
    assign pc_next = pc_load ? pc_d : pc_q;

    lc3b_register #(.WIDTH(16), .RESET_VAL(RESET_PC)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .data_in  (pc_d),
        .data_out (pc_q)
    );

    lc3b_register #(.WIDTH(16), .RESET_VAL(RESET_PC)) u_addr (
        .clk      (clk),
        .reset    (reset),
        .load     (addr_load),
        .data_in  (pc_next),
        .data_out (imem_address)
    );

    lc3b_register #(.WIDTH(16), .RESET_VAL(16'h0000)) u_ir (
        .clk      (clk),
        .reset    (reset),
        .load     (ir_load),
        .data_in  (imem_rdata),
        .data_out (if_ir)
    );

    lc3b_register #(.WIDTH(16), .RESET_VAL(16'h0000)) u_fetch_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (ir_load),
        .data_in  (pc_q),
        .data_out (if_pc)
    );

    assign if_pc_plus2 = if_pc + LC3B_PC_INC;
    assign opcode      = if_ir[15:12];
    assign bit11       = if_ir[11];
    assign bit5        = if_ir[5];
    assign bit4        = if_ir[4];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit: a default-reset instance
// for the main sequence and a RESET_PC=16'hFFFE instance for pc wrap.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Default instance
    logic        reset = 1'b1;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [15:0] if_ir, if_pc, if_pc_plus2;
    logic [3:0]  opcode;
    logic        bit11, bit5, bit4;

    // Wrap instance
    logic        w_reset = 1'b1;
    logic        w_imem_read;
    logic [15:0] w_imem_address;
    logic        w_imem_resp = 1'b0;
    logic [15:0] w_imem_rdata = '0;
    logic        w_id_ready = 1'b0;
    logic        w_if_valid;
    logic [15:0] w_if_ir, w_if_pc, w_if_pc_plus2;
    logic [3:0]  w_opcode;
    logic        w_bit11, w_bit5, w_bit4;

    ifetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc),
        .if_pc_plus2(if_pc_plus2), .opcode(opcode),
        .bit11(bit11), .bit5(bit5), .bit4(bit4)
    );

    ifetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .reset(w_reset),
        .imem_read(w_imem_read), .imem_address(w_imem_address),
        .imem_resp(w_imem_resp), .imem_rdata(w_imem_rdata),
        .redirect(1'b0), .redirect_pc(16'h0000),
        .id_ready(w_id_ready),
        .if_valid(w_if_valid), .if_ir(w_if_ir), .if_pc(w_if_pc),
        .if_pc_plus2(w_if_pc_plus2), .opcode(w_opcode),
        .bit11(w_bit11), .bit5(w_bit5), .bit4(w_bit4)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs,
                            input logic [15:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        check_eq("rst_read",   {15'd0, imem_read}, 16'h0000);
        check_eq("rst_valid",  {15'd0, if_valid},  16'h0000);
        check_eq("rst_ir",     if_ir,              16'h0000);
        check_eq("rst_opcode", {12'd0, opcode},    16'h0000);
        check_eq("rst_addr",   imem_address,       16'h0000);

        // First fetch
        reset = 1'b0;
        #1;
        check_eq("idle_read", {15'd0, imem_read}, 16'h0000);
        tick();
        check_eq("f1_read", {15'd0, imem_read}, 16'h0001);
        check_eq("f1_addr", imem_address,       16'h0000);
        imem_resp  = 1'b1;
        imem_rdata = 16'h1042;
        tick();
        imem_resp = 1'b0;
        check_eq("f1_valid",  {15'd0, if_valid}, 16'h0001);
        check_eq("f1_ir",     if_ir,             16'h1042);
        check_eq("f1_opcode", {12'd0, opcode},   16'h0001);
        check_eq("f1_bit5",   {15'd0, bit5},     16'h0000);
        check_eq("f1_pc",     if_pc,             16'h0000);
        check_eq("f1_pc2",    if_pc_plus2,       16'h0002);

        // Stall in HOLD
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_ir",    if_ir,              16'h1042);
            check_eq("stall_read",  {15'd0, imem_read}, 16'h0000);
            check_eq("stall_valid", {15'd0, if_valid},  16'h0001);
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check_eq("f2_addr",  imem_address,       16'h0002);
        check_eq("f2_read",  {15'd0, imem_read}, 16'h0001);
        check_eq("f2_valid", {15'd0, if_valid},  16'h0000);

        // Redirect in FETCH without response -> DISCARD
        redirect    = 1'b1;
        redirect_pc = 16'h3001;
        tick();
        redirect = 1'b0;
        check_eq("disc_addr",  imem_address,       16'h0002);
        check_eq("disc_read",  {15'd0, imem_read}, 16'h0001);
        tick();
        check_eq("disc_addr2", imem_address,       16'h0002);
        imem_resp  = 1'b1;
        imem_rdata = 16'hBEEF;
        tick();
        imem_resp = 1'b0;
        check_eq("disc_valid", {15'd0, if_valid}, 16'h0000);
        check_eq("rd1_addr",   imem_address,      16'h3000);
        check_eq("rd1_read",   {15'd0, imem_read}, 16'h0001);
        imem_resp  = 1'b1;
        imem_rdata = 16'h2A30;
        tick();
        imem_resp = 1'b0;
        check_eq("rd1_valid",  {15'd0, if_valid}, 16'h0001);
        check_eq("rd1_ir",     if_ir,             16'h2A30);
        check_eq("rd1_pc",     if_pc,             16'h3000);
        check_eq("rd1_pc2",    if_pc_plus2,       16'h3002);
        check_eq("rd1_opcode", {12'd0, opcode},   16'h0002);
        check_eq("rd1_bits",   {13'd0, bit11, bit5, bit4}, 16'h0007);

        // Redirect in HOLD together with id_ready
        redirect    = 1'b1;
        redirect_pc = 16'h4005;
        id_ready    = 1'b1;
        tick();
        id_ready = 1'b0;
        check_eq("rdh_addr",  imem_address,      16'h4004);
        check_eq("rdh_valid", {15'd0, if_valid}, 16'h0000);

        // Redirect in FETCH coinciding with response
        redirect_pc = 16'h5000;
        imem_resp   = 1'b1;
        imem_rdata  = 16'hDEAD;
        tick();
        redirect = 1'b0;
        check_eq("rdr_addr",  imem_address,      16'h5000);
        check_eq("rdr_valid", {15'd0, if_valid}, 16'h0000);
        imem_rdata = 16'h0123;
        tick();
        imem_resp = 1'b0;
        check_eq("rdr_ir", if_ir, 16'h0123);
        check_eq("rdr_pc", if_pc, 16'h5000);

        // Async reset while in DISCARD
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check_eq("ar_addr", imem_address, 16'h5002);
        redirect    = 1'b1;
        redirect_pc = 16'h6000;
        tick();
        redirect = 1'b0;
        check_eq("ar_disc_read", {15'd0, imem_read}, 16'h0001);
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_read",   {15'd0, imem_read}, 16'h0000);
        check_eq("ar_valid",  {15'd0, if_valid},  16'h0000);
        check_eq("ar_ir",     if_ir,              16'h0000);
        check_eq("ar_opcode", {12'd0, opcode},    16'h0000);
        check_eq("ar_addr0",  imem_address,       16'h0000);
        imem_resp  = 1'b1;
        imem_rdata = 16'h7777;
        tick();
        imem_resp = 1'b0;
        check_eq("ar_late_valid", {15'd0, if_valid}, 16'h0000);
        reset = 1'b0;
        tick();
        check_eq("ar_re_valid", {15'd0, if_valid},  16'h0000);
        check_eq("ar_re_read",  {15'd0, imem_read}, 16'h0001);
        check_eq("ar_re_addr",  imem_address,       16'h0000);

        // PC wrap on the RESET_PC=FFFE instance
        w_reset = 1'b0;
        tick();
        check_eq("wr_addr", w_imem_address, 16'hFFFE);
        w_imem_resp  = 1'b1;
        w_imem_rdata = 16'hABCD;
        tick();
        w_imem_resp = 1'b0;
        check_eq("wr_valid", {15'd0, w_if_valid}, 16'h0001);
        check_eq("wr_pc",    w_if_pc,             16'hFFFE);
        check_eq("wr_pc2",   w_if_pc_plus2,       16'h0000);
        w_id_ready = 1'b1;
        tick();
        w_id_ready = 1'b0;
        check_eq("wr_next_addr", w_imem_address, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
